// File: rtl/spike_rate_decoder_if.sv
// Handshake/result bundle between spike_rate_decoder and its host.
// The host side drives start, spikes_in and result_ready; the decoder drives the rest.
interface spike_rate_decoder_if #(
  parameter int NUM_OUTPUTS = 2,
  parameter int CNT_WIDTH   = 8,
  parameter int IDX_WIDTH   = 1
);
  logic                   start;
  logic [NUM_OUTPUTS-1:0] spikes_in;
  logic                   busy;
  logic                   result_valid;
  logic                   result_ready;
  logic [IDX_WIDTH-1:0]   winner;
  logic [CNT_WIDTH-1:0]   winner_count;
  logic                   tie;
  logic                   no_spike;

  modport master (
    output start, spikes_in, result_ready,
    input  busy, result_valid, winner, winner_count, tie, no_spike
  );

  modport slave (
    input  start, spikes_in, result_ready,
    output busy, result_valid, winner, winner_count, tie, no_spike
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts spikes per output neuron over a fixed window and reports the argmax
// neuron through a valid/ready handshake.
module spike_rate_decoder #(
  parameter int NUM_OUTPUTS = 2,
  parameter int WINDOW      = 64,
  parameter int CNT_WIDTH   = 8,
  parameter int IDX_WIDTH   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  spike_rate_decoder_if.slave  bus
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COUNT   = 2'd1;
  localparam logic [1:0] S_COMPARE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int                   WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [IDX_WIDTH-1:0] CMP_LAST = IDX_WIDTH'(NUM_OUTPUTS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  logic [1:0]           state_r;
  logic [WIN_W-1:0]     win_cnt_r;
  logic [IDX_WIDTH-1:0] cmp_idx_r;
  logic [CNT_WIDTH-1:0] cnt_r [NUM_OUTPUTS];
  logic [IDX_WIDTH-1:0] best_idx_r;
  logic [CNT_WIDTH-1:0] best_cnt_r;
  logic                 best_tie_r;
  logic                 busy_r;
  logic                 valid_r;
  logic [IDX_WIDTH-1:0] winner_r;
  logic [CNT_WIDTH-1:0] winner_count_r;
  logic                 tie_r;
  logic                 no_spike_r;

  logic                 start_accept_s;
  logic [CNT_WIDTH-1:0] cur_cnt_s;
  logic [IDX_WIDTH-1:0] nb_idx_s;
  logic [CNT_WIDTH-1:0] nb_cnt_s;
  logic                 nb_tie_s;

  // A new window may open from IDLE, or from DONE on the same edge as a transfer.
  always_comb begin
    if (state_r == S_IDLE) begin
      start_accept_s = bus.start;
    end else if (state_r == S_DONE) begin
      start_accept_s = bus.start & bus.result_ready;
    end else begin
      start_accept_s = 1'b0;
    end
  end

  // One step of the argmax scan; equal counts keep the lower index and flag a tie.
  always_comb begin
    cur_cnt_s = cnt_r[cmp_idx_r];
    nb_idx_s  = best_idx_r;
    nb_cnt_s  = best_cnt_r;
    nb_tie_s  = best_tie_r;
    if (cmp_idx_r == {IDX_WIDTH{1'b0}}) begin
      nb_idx_s = {IDX_WIDTH{1'b0}};
      nb_cnt_s = cur_cnt_s;
      nb_tie_s = 1'b0;
    end else if (cur_cnt_s > best_cnt_r) begin
      nb_idx_s = cmp_idx_r;
      nb_cnt_s = cur_cnt_s;
      nb_tie_s = 1'b0;
    end else if (cur_cnt_s == best_cnt_r) begin
      nb_tie_s = 1'b1;
    end else begin
      nb_tie_s = best_tie_r;
    end
  end

  // Per-neuron saturating spike counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) cnt_r[i] <= {CNT_WIDTH{1'b0}};
    end else if (start_accept_s) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) cnt_r[i] <= {CNT_WIDTH{1'b0}};
    end else if (state_r == S_COUNT) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        if (bus.spikes_in[i] && (cnt_r[i] != CNT_MAX)) cnt_r[i] <= cnt_r[i] + CNT_WIDTH'(1);
      end
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= S_IDLE;
      win_cnt_r      <= {WIN_W{1'b0}};
      cmp_idx_r      <= {IDX_WIDTH{1'b0}};
      best_idx_r     <= {IDX_WIDTH{1'b0}};
      best_cnt_r     <= {CNT_WIDTH{1'b0}};
      best_tie_r     <= 1'b0;
      busy_r         <= 1'b0;
      valid_r        <= 1'b0;
      winner_r       <= {IDX_WIDTH{1'b0}};
      winner_count_r <= {CNT_WIDTH{1'b0}};
      tie_r          <= 1'b0;
      no_spike_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_accept_s) begin
            state_r   <= S_COUNT;
            busy_r    <= 1'b1;
            win_cnt_r <= {WIN_W{1'b0}};
          end
        end
        S_COUNT: begin
          win_cnt_r <= win_cnt_r + WIN_W'(1);
          if (win_cnt_r == WIN_LAST) begin
            state_r   <= S_COMPARE;
            cmp_idx_r <= {IDX_WIDTH{1'b0}};
          end
        end
        S_COMPARE: begin
          best_idx_r <= nb_idx_s;
          best_cnt_r <= nb_cnt_s;
          best_tie_r <= nb_tie_s;
          if (cmp_idx_r == CMP_LAST) begin
            state_r        <= S_DONE;
            busy_r         <= 1'b0;
            valid_r        <= 1'b1;
            winner_r       <= nb_idx_s;
            winner_count_r <= nb_cnt_s;
            tie_r          <= nb_tie_s;
            no_spike_r     <= (nb_cnt_s == {CNT_WIDTH{1'b0}});
          end else begin
            cmp_idx_r <= cmp_idx_r + IDX_WIDTH'(1);
          end
        end
        S_DONE: begin
          if (bus.result_ready) begin
            valid_r <= 1'b0;
            if (start_accept_s) begin
              state_r   <= S_COUNT;
              busy_r    <= 1'b1;
              win_cnt_r <= {WIN_W{1'b0}};
            end else begin
              state_r <= S_IDLE;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_r;
  assign bus.result_valid = valid_r;
  assign bus.winner       = winner_r;
  assign bus.winner_count = winner_count_r;
  assign bus.tie          = tie_r;
  assign bus.no_spike     = no_spike_r;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench: dut_a uses an 8-cycle window, dut_b a 20-cycle window for saturation.
module tb_spike_rate_decoder;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  spike_rate_decoder_if #(.NUM_OUTPUTS(2), .CNT_WIDTH(4), .IDX_WIDTH(1)) ifa ();
  spike_rate_decoder_if #(.NUM_OUTPUTS(2), .CNT_WIDTH(4), .IDX_WIDTH(1)) ifb ();

  spike_rate_decoder #(.NUM_OUTPUTS(2), .WINDOW(8), .CNT_WIDTH(4), .IDX_WIDTH(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  spike_rate_decoder #(.NUM_OUTPUTS(2), .WINDOW(20), .CNT_WIDTH(4), .IDX_WIDTH(1)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    ifa.start = 1'b0; ifa.spikes_in = 2'b00; ifa.result_ready = 1'b0;
    ifb.start = 1'b0; ifb.spikes_in = 2'b00; ifb.result_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", ifa.busy, 0);
    chk("rst_valid", ifa.result_valid, 0);
    chk("rst_winner", ifa.winner, 0);
    chk("rst_count", ifa.winner_count, 0);
    chk("rst_tie", ifa.tie, 0);
    chk("rst_nospike", ifa.no_spike, 0);

    // Basic argmax: neuron 1 fires every cycle.
    ifa.start = 1'b1; ifa.spikes_in = 2'b10;
    tick();
    ifa.start = 1'b0;
    chk("basic_busy", ifa.busy, 1);
    for (int n = 1; n <= 9; n++) tick();
    chk("basic_valid_early", ifa.result_valid, 0);
    tick();
    chk("basic_valid", ifa.result_valid, 1);
    chk("basic_winner", ifa.winner, 1);
    chk("basic_count", ifa.winner_count, 8);
    chk("basic_tie", ifa.tie, 0);
    chk("basic_nospike", ifa.no_spike, 0);
    chk("basic_busy_done", ifa.busy, 0);

    // Hold in DONE with start asserted but no ready: nothing moves.
    ifa.spikes_in = 2'b01;
    ifa.start = 1'b1;
    for (int n = 0; n < 5; n++) tick();
    chk("hold_valid", ifa.result_valid, 1);
    chk("hold_winner", ifa.winner, 1);
    chk("hold_count", ifa.winner_count, 8);
    chk("hold_busy", ifa.busy, 0);

    // Back-to-back transfer straight into a tie window.
    ifa.result_ready = 1'b1;
    tick();
    ifa.result_ready = 1'b0;
    ifa.start = 1'b0;
    chk("b2b_busy", ifa.busy, 1);
    chk("b2b_valid", ifa.result_valid, 0);
    chk("b2b_keep_count", ifa.winner_count, 8);
    for (int i = 0; i < 8; i++) begin
      ifa.spikes_in = i[0] ? 2'b10 : 2'b01;
      ifa.start = (i == 3);
      tick();
    end
    ifa.start = 1'b0;
    ifa.spikes_in = 2'b11;
    tick();
    chk("tie_valid_early", ifa.result_valid, 0);
    tick();
    chk("tie_valid", ifa.result_valid, 1);
    chk("tie_winner", ifa.winner, 0);
    chk("tie_count", ifa.winner_count, 4);
    chk("tie_tie", ifa.tie, 1);
    chk("tie_nospike", ifa.no_spike, 0);
    ifa.result_ready = 1'b1;
    tick();
    ifa.result_ready = 1'b0;
    chk("xfer_valid", ifa.result_valid, 0);
    chk("xfer_busy", ifa.busy, 0);
    chk("xfer_keep_count", ifa.winner_count, 4);
    chk("xfer_keep_tie", ifa.tie, 1);

    // Silence.
    ifa.start = 1'b1; ifa.spikes_in = 2'b00;
    tick();
    ifa.start = 1'b0;
    for (int n = 1; n <= 10; n++) tick();
    chk("sil_valid", ifa.result_valid, 1);
    chk("sil_winner", ifa.winner, 0);
    chk("sil_count", ifa.winner_count, 0);
    chk("sil_nospike", ifa.no_spike, 1);
    chk("sil_tie", ifa.tie, 1);
    ifa.result_ready = 1'b1;
    tick();
    ifa.result_ready = 1'b0;

    // Saturation on the 20-cycle window.
    ifb.start = 1'b1; ifb.spikes_in = 2'b01;
    tick();
    ifb.start = 1'b0;
    for (int n = 1; n <= 21; n++) tick();
    chk("sat_valid_early", ifb.result_valid, 0);
    tick();
    chk("sat_valid", ifb.result_valid, 1);
    chk("sat_count", ifb.winner_count, 15);
    chk("sat_winner", ifb.winner, 0);
    chk("sat_tie", ifb.tie, 0);

    // Asynchronous reset three cycles into COUNT.
    ifa.start = 1'b1; ifa.spikes_in = 2'b11;
    tick();
    ifa.start = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_busy", ifa.busy, 1);
    reset = 1'b1;
    #1;
    chk("arst_busy", ifa.busy, 0);
    chk("arst_valid", ifa.result_valid, 0);
    chk("arst_valid_b", ifb.result_valid, 0);
    tick();
    reset = 1'b0;
    ifa.spikes_in = 2'b00;
    tick();
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ifa.spikes_in = (i < 3) ? 2'b01 : ((i < 5) ? 2'b11 : 2'b00);
      tick();
    end
    ifa.spikes_in = 2'b00;
    tick(); tick();
    chk("fresh_valid", ifa.result_valid, 1);
    chk("fresh_winner", ifa.winner, 0);
    chk("fresh_count", ifa.winner_count, 5);
    chk("fresh_tie", ifa.tie, 0);
    chk("fresh_nospike", ifa.no_spike, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Downstream stage of spiking_neural_network; consumes its output-layer spike vector.
- Counts spikes per output neuron over a fixed observation window.
- Selects the most active neuron (argmax) as the classification result.
- Presents the result with a valid/ready handshake to the host/readout logic.

Parameters:
- NUM_OUTPUTS, 2: number of output neurons/spike lines (>=2).
- WINDOW, 64: observation window length in clock cycles (>=1).
- CNT_WIDTH, 8: width of each per-neuron spike counter (saturating).
- IDX_WIDTH, 1: width of winner index; must satisfy 2^IDX_WIDTH >= NUM_OUTPUTS.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new observation window; sampled only when accepted (see Behaviour).
- spikes_in  input  NUM_OUTPUTS  spike vector from spiking_neural_network outputs; bit i = neuron i fired this cycle.
- busy  output  1  high in COUNT and COMPARE states.
- result_valid  output  1  result fields are valid; held until handshake.
- result_ready  input  1  consumer accepts the result.
- winner  output  IDX_WIDTH  index of neuron with highest count.
- winner_count  output  CNT_WIDTH  spike count of winner.
- tie  output  1  another neuron equals winner_count.
- no_spike  output  1  all counts zero.

Behaviour:
- States: IDLE, COUNT, COMPARE, DONE.
- Reset (async, any state): state=IDLE; all counters, window counter and compare index = 0. Outputs: busy=0, result_valid=0, winner=0, winner_count=0, tie=0, no_spike=0.
- IDLE: on an edge with start=1, clear all per-neuron counters and window counter, then go to COUNT. start=0 stays in IDLE.
- COUNT: each edge, for every i with spikes_in[i]=1, cnt[i] increments. A counter at 2^CNT_WIDTH-1 holds (saturates, no wrap). The window counter increments. On the edge sampling the WINDOW-th cycle, go to COMPARE. Exactly WINDOW samples are taken: edges k+1..k+WINDOW, where edge k accepted start.
- COMPARE: sequential scan, one neuron per edge, index 0..NUM_OUTPUTS-1.
  - Index 0 loads best_idx=0, best_cnt=cnt[0], tie=0.
  - For i>0: if cnt[i] > best_cnt, update best and clear tie. If cnt[i] == best_cnt, set tie and keep the lower index.
  - After the last index, go to DONE.
  - COMPARE lasts exactly NUM_OUTPUTS cycles.
- DONE:
  - result_valid=1. winner, winner_count and tie are stable.
  - no_spike = (winner_count==0). When no_spike=1, tie=1 whenever NUM_OUTPUTS>1 and winner=0.
- Total latency: result_valid rises after edge k+WINDOW+NUM_OUTPUTS.
- Handshake:
  - Transfer occurs on an edge with result_valid & result_ready.
  - On transfer with start=0: go to IDLE, result_valid=0. Result fields keep their last values.
  - On transfer with start=1 the same edge: go directly to COUNT with counters cleared (back-to-back windows, no idle bubble).
- start asserted in COUNT/COMPARE, or in DONE without result_ready: ignored, with no effect on the current window.
- result_ready outside DONE: ignored.
- spikes_in outside COUNT: ignored.
- Reset mid-window or while result_valid=1: the result is discarded immediately and the block returns to IDLE.
- Arithmetic: unsigned compare only; no overflow beyond saturation.

Test Plan (NUM_OUTPUTS=2, WINDOW=8, CNT_WIDTH=4 unless noted):
- Basic argmax: start for 1 cycle, spikes_in=2'b10 for all 8 COUNT cycles. Required: result_valid high exactly 10 cycles after the start edge; winner=1, winner_count=8, tie=0, no_spike=0.
- Tie: spikes_in alternates 2'b01, 2'b10 over the window. Required: counts 4/4, winner=0, winner_count=4, tie=1.
- Silence: spikes_in=0 throughout. Required: winner=0, winner_count=0, no_spike=1, tie=1.
- Saturation (WINDOW=20, CNT_WIDTH=4): spikes_in=2'b01 every cycle. Required: winner_count=15 (not 4), winner=0.
- Handshake/back-to-back: hold result_ready=0 for 5 cycles in DONE. Required: fields and result_valid stable. Then assert result_ready with start=1 on the same edge; required: busy=1 next cycle and a second result after 10 more cycles. A start pulse during COUNT must not restart the window.
- Reset mid-operation: assert reset 3 cycles into COUNT. Required: busy=0 and result_valid=0 immediately (asynchronous). After release, a fresh start gives correct counts with no residue from the aborted window.
